// File: rtl/scan_pkg.sv
// Shared types and constants for the multiplexed scan framer.
// Frame length depends on SCAN_CHECKSUM_EN (adds one trailing XOR byte when defined).
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESERVE,
        SETTLE,
        ACCUM,
        EMIT,
        TRAILER
    } scan_state_t;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    function automatic int frame_len(input int n_ch, input int out_bytes);
`ifdef SCAN_CHECKSUM_EN
        return 3 + n_ch * out_bytes;
`else
        return 2 + n_ch * out_bytes;
`endif
    endfunction

endpackage

// File: rtl/scan_byte_fifo.sv
// Synchronous byte FIFO with registered read data and a free-space count.
// q holds its value except on the edge where a pop happens.
module scan_byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [7:0]               din,
    input  logic                     rd_en,
    output logic [7:0]               q,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));
    assign free  = (AW + 1)'(DEPTH) - count;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q      <= 8'h00;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
                q      <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mux_scan_framer.sv
// Mux scan engine: settle, average, and frame each channel into a byte FIFO.
// Optional SCAN_CHECKSUM_EN appends an XOR-of-frame byte in TRAILER.
module mux_scan_framer
    import scan_pkg::*;
#(
    parameter int N_CH       = 24,
    parameter int SEL_W      = $clog2(N_CH),
    parameter int SAMPLE_W   = 12,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 256,
    parameter int OUT_BYTES  = 1,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                cont,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic [SEL_W-1:0]    mux_addr,
    input  logic                rd_en,
    output logic [7:0]          q,
    output logic                empty,
    output logic                busy,
    output logic                overflow
);

    localparam int FLEN  = frame_len(N_CH, OUT_BYTES);
    localparam int SUM_W = SAMPLE_W + AVG_LOG2;
    localparam int NAVG  = 1 << AVG_LOG2;
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int AC_W  = AVG_LOG2 + 1;
    localparam int FW    = $clog2(FIFO_DEPTH) + 1;

    scan_state_t         state, next_state;
    logic [SEL_W-1:0]    channel;
    logic [ST_W-1:0]     settle_cnt;
    logic [AC_W-1:0]     acc_cnt;
    logic                byte_idx;
    logic [7:0]          frame_cnt;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_next;
    logic [SAMPLE_W-1:0] avg;
    logic [15:0]         avg_ext;
    logic [7:0]          data_byte;
    logic                push;
    logic [7:0]          push_byte;
    logic                fifo_full;
    logic [FW-1:0]       fifo_free;
    logic                room;
    logic                acc_done;
    logic                emit_last;
    logic                last_ch;
`ifdef SCAN_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign mux_addr  = channel;
    assign busy      = (state != IDLE);
    assign room      = (fifo_free >= FW'(FLEN));
    assign sum_next  = sum + SUM_W'(adc_data);
    assign acc_done  = (state == ACCUM) && adc_valid && (acc_cnt == AC_W'(NAVG - 1));
    assign emit_last = (byte_idx == 1'(OUT_BYTES - 1));
    assign last_ch   = (channel == SEL_W'(N_CH - 1));
    assign avg_ext   = 16'(avg);
    assign data_byte = (OUT_BYTES == 1) ? avg[SAMPLE_W-1 -: 8]
                     : (byte_idx ? avg_ext[7:0] : avg_ext[15:8]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        push       = 1'b0;
        push_byte  = FRAME_HDR;
        case (state)
            IDLE:    if (start) next_state = RESERVE;
            RESERVE: begin
                if (!byte_idx) begin
                    if (room) push = 1'b1;
                    else      next_state = cont ? RESERVE : IDLE;
                end else begin
                    push       = 1'b1;
                    push_byte  = frame_cnt;
                    next_state = SETTLE;
                end
            end
            SETTLE:  if (settle_cnt == ST_W'(SETTLE_CYC - 1)) next_state = ACCUM;
            ACCUM:   if (acc_done) next_state = EMIT;
            EMIT: begin
                push      = 1'b1;
                push_byte = data_byte;
                if (emit_last) next_state = last_ch ? TRAILER : SETTLE;
            end
            TRAILER: begin
`ifdef SCAN_CHECKSUM_EN
                push      = 1'b1;
                push_byte = csum;
`endif
                next_state = cont ? RESERVE : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            channel    <= '0;
            settle_cnt <= '0;
            acc_cnt    <= '0;
            byte_idx   <= 1'b0;
            frame_cnt  <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            case (state)
                RESERVE: begin
                    if (!byte_idx) begin
                        if (room) begin
                            byte_idx <= 1'b1;
                        end else begin
                            // Dropped frames still consume a counter value.
                            overflow  <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end else begin
                        byte_idx   <= 1'b0;
                        channel    <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + ST_W'(1);
                    acc_cnt    <= '0;
                end
                ACCUM:   if (adc_valid) acc_cnt <= acc_cnt + AC_W'(1);
                EMIT: begin
                    if (emit_last) begin
                        byte_idx <= 1'b0;
                        if (!last_ch) begin
                            channel    <= channel + SEL_W'(1);
                            settle_cnt <= '0;
                        end
                    end else begin
                        byte_idx <= 1'b1;
                    end
                end
                TRAILER: frame_cnt <= frame_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == SETTLE) begin
            sum <= '0;
        end else if (state == ACCUM && adc_valid) begin
            sum <= sum_next;
            if (acc_done) avg <= sum_next[SUM_W-1:AVG_LOG2];
        end
    end

`ifdef SCAN_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  csum <= 8'h00;
        else if (push) csum <= (state == RESERVE && !byte_idx) ? push_byte : (csum ^ push_byte);
    end
`endif

    scan_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push && !fifo_full),
        .din     (push_byte),
        .rd_en   (rd_en),
        .q       (q),
        .empty   (empty),
        .full    (fifo_full),
        .free    (fifo_free)
    );

endmodule

// File: tb/tb_mux_scan_framer.sv
// Scoreboard bench for mux_scan_framer: two configurations, expected bytes queued at stimulus time.
module tb_mux_scan_framer;

    localparam int S_A = 8;
    localparam int P_A = S_A + 5;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        start_a, cont_a, adc_valid_a, rd_en_a;
    logic [11:0] adc_data_a;
    logic [1:0]  mux_addr_a;
    logic [7:0]  q_a;
    logic        empty_a, busy_a, overflow_a;

    logic        start_b, cont_b, adc_valid_b, rd_en_b;
    logic [11:0] adc_data_b;
    logic [0:0]  mux_addr_b;
    logic [7:0]  q_b;
    logic        empty_b, busy_b, overflow_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    initial forever #5 clk = ~clk;

    mux_scan_framer #(
        .N_CH(4), .SAMPLE_W(12), .AVG_LOG2(2), .SETTLE_CYC(S_A),
        .OUT_BYTES(1), .FIFO_DEPTH(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .cont(cont_a),
        .adc_valid(adc_valid_a), .adc_data(adc_data_a), .mux_addr(mux_addr_a),
        .rd_en(rd_en_a), .q(q_a), .empty(empty_a), .busy(busy_a), .overflow(overflow_a)
    );

    mux_scan_framer #(
        .N_CH(2), .SAMPLE_W(12), .AVG_LOG2(1), .SETTLE_CYC(4),
        .OUT_BYTES(2), .FIFO_DEPTH(16)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .cont(cont_b),
        .adc_valid(adc_valid_b), .adc_data(adc_data_b), .mux_addr(mux_addr_b),
        .rd_en(rd_en_b), .q(q_b), .empty(empty_b), .busy(busy_b), .overflow(overflow_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_byte(input bit to_b, input logic [7:0] v);
        if (to_b) sb_b.push_back(v);
        else      sb_a.push_back(v);
    endtask

    // Header, counter, per-channel bytes (hi only when two bytes/channel), optional XOR trailer.
    task automatic exp_frame(input bit to_b, input logic [7:0] cnt, input int n_ch,
                             input int bpc, input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] x;
        x = 8'hA5 ^ cnt;
        exp_byte(to_b, 8'hA5);
        exp_byte(to_b, cnt);
        for (int ch = 0; ch < n_ch; ch++) begin
            if (bpc == 2) begin
                exp_byte(to_b, hi);
                x = x ^ hi;
            end
            exp_byte(to_b, lo);
            x = x ^ lo;
        end
`ifdef SCAN_CHECKSUM_EN
        exp_byte(to_b, x);
`endif
    endtask

    task automatic pulse_start(input bit to_b);
        if (to_b) start_b = 1'b1;
        else      start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input bit to_b, input int bound);
        int n;
        n = 0;
        while ((to_b ? busy_b : busy_a) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(to_b ? "idle_timeout_b" : "idle_timeout_a", to_b ? busy_b : busy_a, 1'b0);
    endtask

    task automatic drain(input bit to_b, input int cycles);
        if (to_b) rd_en_b = 1'b1;
        else      rd_en_a = 1'b1;
        repeat (cycles) @(negedge clk);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        @(negedge clk);
        check(to_b ? "bytes_left_b" : "bytes_left_a", to_b ? sb_b.size() : sb_a.size(), 0);
        check(to_b ? "empty_after_drain_b" : "empty_after_drain_a", to_b ? empty_b : empty_a, 1'b1);
    endtask

    function automatic logic [11:0] settle_pattern(input int c);
        int o;
        if (c < 2) return 12'hFFF;
        o = (c - 2) % P_A;
        return (o >= S_A && o < S_A + 4) ? 12'h100 : 12'hFFF;
    endfunction

    initial begin : mon_a
        bit pa;
        forever begin
            @(posedge clk);
            pa = rd_en_a && !empty_a;
            #1;
            if (pa) begin
                if (sb_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_a: got byte %02h, expected none", q_a);
                end else begin
                    check("q_a", q_a, sb_a.pop_front());
                end
            end
        end
    end

    initial begin : mon_b
        bit pb;
        forever begin
            @(posedge clk);
            pb = rd_en_b && !empty_b;
            #1;
            if (pb) begin
                if (sb_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_b: got byte %02h, expected none", q_b);
                end else begin
                    check("q_b", q_b, sb_b.pop_front());
                end
            end
        end
    end

    // Sparse strobes alternating 0x001/0x002: any accepted pair averages to 1.
    initial begin : adc_b_drv
        int k;
        bit tog;
        k = 0;
        tog = 1'b0;
        adc_valid_b = 1'b0;
        adc_data_b  = 12'h001;
        forever begin
            @(negedge clk);
            k++;
            if (k % 3 == 0) begin
                adc_valid_b = 1'b1;
                tog = ~tog;
                adc_data_b = tog ? 12'h002 : 12'h001;
            end else begin
                adc_valid_b = 1'b0;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0; cont_a = 1'b0; rd_en_a = 1'b0;
        adc_valid_a = 1'b0; adc_data_a = 12'h000;
        start_b = 1'b0; cont_b = 1'b0; rd_en_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mux_addr_a", mux_addr_a, 0);
        check("rst_q_a", q_a, 8'h00);
        check("rst_empty_a", empty_a, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_overflow_a", overflow_a, 1'b0);
        check("rst_empty_b", empty_b, 1'b1);
        check("rst_busy_b", busy_b, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Continuous mode: frames 00 and 01 fit, the next request is dropped.
        adc_valid_a = 1'b1;
        adc_data_a  = 12'h5A0;
        cont_a      = 1'b1;
        exp_frame(1'b0, 8'h00, 4, 1, 8'h00, 8'h5A);
        exp_frame(1'b0, 8'h01, 4, 1, 8'h00, 8'h5A);
        pulse_start(1'b0);
        check("busy_after_start_a", busy_a, 1'b1);
        repeat (80) @(negedge clk);
        cont_a = 1'b0;
        wait_idle(1'b0, 200);
        check("ovf_before_drop", overflow_a, 1'b0);
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        check("busy_after_drop", busy_a, 1'b0);
        check("ovf_after_drop", overflow_a, 1'b1);
        drain(1'b0, 40);

        // Counter advanced past the dropped frame.
        adc_data_a = 12'hABC;
        exp_frame(1'b0, 8'h03, 4, 1, 8'h00, 8'hAB);
        pulse_start(1'b0);
        wait_idle(1'b0, 200);
        drain(1'b0, 20);
        check("ovf_sticky", overflow_a, 1'b1);

        // Strobes during settling carry 0xFFF and must not reach the average.
        exp_frame(1'b0, 8'h04, 4, 1, 8'h00, 8'h10);
        pulse_start(1'b0);
        for (int c = 0; c < 2 + 4 * P_A + 3; c++) begin
            adc_data_a = settle_pattern(c);
            @(negedge clk);
        end
        wait_idle(1'b0, 200);
        drain(1'b0, 20);

        // Two bytes per channel, truncating average of 1 and 2.
        exp_frame(1'b1, 8'h00, 2, 2, 8'h00, 8'h01);
        pulse_start(1'b1);
        check("busy_after_start_b", busy_b, 1'b1);
        wait_idle(1'b1, 300);
        drain(1'b1, 20);

        // Reset while accumulating channel 1.
        adc_data_a = 12'hABC;
        pulse_start(1'b0);
        repeat (S_A + P_A + 3) @(negedge clk);
        check("pre_rst_mux_addr_a", mux_addr_a, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_mux_addr_a", mux_addr_a, 0);
        check("mid_rst_q_a", q_a, 8'h00);
        check("mid_rst_empty_a", empty_a, 1'b1);
        check("mid_rst_busy_a", busy_a, 1'b0);
        check("mid_rst_overflow_a", overflow_a, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        exp_frame(1'b0, 8'h00, 4, 1, 8'h00, 8'hAB);
        pulse_start(1'b0);
        wait_idle(1'b0, 200);
        check("data_present_at_idle", empty_a, 1'b0);
        drain(1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_framer.md
# mux_scan_framer

Parametrised scan engine for the multiplexed pressure-sensor array. Steps a binary channel address through N_CH analogue-mux inputs, waits a settling time, and averages 2^AVG_LOG2 ADC conversions per channel. Packs each scan into a framed byte stream: header, frame counter, per-channel data. The stream goes through an internal byte FIFO to the UART transmitter. It sits between the LTC2315 capture block, the mux address decoder and the UART, and replaces the fixed 8-bit, unframed polling controller.

## Interface
- N_CH, 24: channels per scan (2..64).
- SEL_W, $clog2(N_CH): mux address width.
- SAMPLE_W, 12: ADC sample width.
- AVG_LOG2, 2: log2 of conversions averaged per channel (0..4).
- SETTLE_CYC, 256: clk cycles after an address change before samples are accepted (≥1).
- OUT_BYTES, 1: bytes per channel; 1 sends avg[SAMPLE_W-1 -: 8], 2 sends avg zero-extended to 16 bits, MSB first.
- FIFO_DEPTH, 64: byte FIFO depth (power of two, ≥ frame length).
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- cont  in  1  continuous mode; sampled at end of each frame.
- adc_valid  in  1  one-cycle strobe, new conversion on adc_data.
- adc_data  in  SAMPLE_W  conversion result.
- mux_addr  out  SEL_W  channel select to the mux decoder.
- rd_en  in  1  FIFO read request from UART.
- q  out  8  FIFO read data.
- empty  out  1  FIFO empty.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; a frame was dropped for lack of FIFO space.

## Operation
- Frame = 0xA5, frame counter (8-bit, wraps 255→0), then N_CH×OUT_BYTES data bytes in channel order 0..N_CH-1. FLEN = 2 + N_CH×OUT_BYTES (+1 with checksum).
- FSM states: IDLE, RESERVE, SETTLE, ACCUM, EMIT, TRAILER.
- IDLE → RESERVE on start. start in any other state is ignored.
- RESERVE: if FIFO free ≥ FLEN, push header then counter (one byte/cycle) and go to SETTLE with channel 0. Otherwise set overflow, increment frame counter, drop the whole frame, then go to IDLE, or to RESERVE again if cont=1.
- SETTLE: mux_addr = channel. A counter runs SETTLE_CYC cycles. adc_valid is ignored. Then go to ACCUM.
- ACCUM: sum += adc_data on each adc_valid. Sum is SAMPLE_W+AVG_LOG2 bits. After 2^AVG_LOG2 strobes, avg = sum >> AVG_LOG2 (truncating), and go to EMIT.
- EMIT: push OUT_BYTES bytes, one per cycle. If last channel, go to TRAILER. Otherwise increment channel and go to SETTLE.
- TRAILER: push checksum (if enabled) and increment frame counter. Then cont=1 → RESERVE, cont=0 → IDLE.
- The RESERVE check guarantees no FIFO write occurs while full. Space is never re-checked mid-frame.
- FIFO read: rd_en && !empty pops; rd_en while empty is ignored. Read and write in the same cycle are both honoured.
- overflow clears only on reset.

## Timing
- Reset values: mux_addr=0, q=0x00, empty=1, busy=0, overflow=0, frame counter=0, FSM=IDLE, FIFO cleared.
- start accepted on the same edge; busy high the next cycle.
- mux_addr changes on the edge entering SETTLE. First accepted sample is the first adc_valid at or after SETTLE_CYC cycles later.
- q updates on the edge where a pop occurs and holds otherwise. empty updates the same edge.
- A byte written at edge t is visible (empty=0) after edge t.
- Reset mid-frame aborts at once. No partial frame survives.

## Configuration
- SCAN_CHECKSUM_EN defined: TRAILER appends one byte, the XOR of all frame bytes including header and counter, and FLEN includes it.
- Not defined: no checksum byte, and TRAILER only advances the counter.

## Structure
- Package scan_pkg holds: FSM state enum, header constant 0xA5, and a FLEN helper function of N_CH, OUT_BYTES and the macro.
- One sub-module, scan_byte_fifo: synchronous byte FIFO parametrised by depth, exposing wr_en, din, rd_en, q, empty, full and a free-count output.

## Test plan
- N_CH=4, AVG_LOG2=2, constant adc_data=0xABC, one start → FIFO drains A5 00 AB AB AB AB. busy falls after the last push.
- OUT_BYTES=2, adc_data alternating 0x001/0x002, AVG_LOG2=1 → each channel 0x0001 (truncation), bytes 00 01.
- adc_valid strobes inside SETTLE carry 0xFFF, later strobes carry 0x100 → output 0x10. Settle samples are excluded.
- cont=1, UART never reads, FIFO_DEPTH=16, FLEN=6 → two frames stored. The third is dropped with overflow=1 and the counter still advancing, so the next stored frame has counter 03.
- reset_n low mid-ACCUM → all outputs return to reset values immediately. After restart the first frame counter is 00.
- SCAN_CHECKSUM_EN, N_CH=2, data 0x120 → A5 00 12 12 A5 (XOR).
